// File: rtl/gray_fifo_ptr.sv
// Gray-coded pointer for one side of an asynchronous FIFO. Registers the binary
// and Gray pointer, the full/empty flag and the occupancy against the other side's Gray pointer.
module gray_fifo_ptr #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter bit          MODE       = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  inc,
   input  logic                  clr,
   input  logic [ADDR_WIDTH:0]   sync_gray_ptr,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [ADDR_WIDTH:0]   bin_ptr,
   output logic [ADDR_WIDTH:0]   gray_ptr,
   output logic                  flag,
   output logic [ADDR_WIDTH:0]   level
);

   logic                inc_eff;
   logic [ADDR_WIDTH:0] bin_next;
   logic [ADDR_WIDTH:0] gray_next;
   logic [ADDR_WIDTH:0] sync_bin;
   logic [ADDR_WIDTH:0] full_pat;
   logic [ADDR_WIDTH:0] level_next;
   logic                flag_next;

   always_comb begin
      inc_eff   = inc & ~flag;
      bin_next  = bin_ptr + {{ADDR_WIDTH{1'b0}}, inc_eff};
      gray_next = bin_next ^ (bin_next >> 1);
   end

   // Gray-to-binary: prefix XOR running down from the MSB.
   always_comb begin
      sync_bin             = '0;
      sync_bin[ADDR_WIDTH] = sync_gray_ptr[ADDR_WIDTH];
      for (int unsigned i = ADDR_WIDTH; i > 0; i--) begin
         sync_bin[i-1] = sync_bin[i] ^ sync_gray_ptr[i-1];
      end
   end

   // Full when our next pointer is exactly one lap ahead: Gray of (x + depth)
   // differs from Gray of x only in the two top bits.
   always_comb begin
      full_pat = {~sync_gray_ptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_gray_ptr[ADDR_WIDTH-2:0]};
      if (MODE) begin
         flag_next  = (gray_next == sync_gray_ptr);
         level_next = sync_bin - bin_next;
      end else begin
         flag_next  = (gray_next == full_pat);
         level_next = bin_next - sync_bin;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bin_ptr  <= '0;
         gray_ptr <= '0;
         level    <= '0;
         flag     <= MODE;
      end else if (clr) begin
         bin_ptr  <= '0;
         gray_ptr <= '0;
         level    <= '0;
         flag     <= MODE;
      end else begin
         bin_ptr  <= bin_next;
         gray_ptr <= gray_next;
         level    <= level_next;
         flag     <= flag_next;
      end
   end

   assign addr = bin_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_gray_fifo_ptr.sv
// Bench for gray_fifo_ptr: four instances (ADDR_WIDTH 3/5, write/read side) checked
// every cycle against a binary-arithmetic occupancy model, plus literal spot checks.
module tb_gray_fifo_ptr;

   logic       clk = 1'b0;
   logic       rst;
   logic       inc [4];
   logic       clr [4];
   logic [5:0] sync [4];
   logic [5:0] o_bin [4];
   logic [5:0] o_gray [4];
   logic [5:0] o_lvl [4];
   logic [4:0] o_addr [4];
   logic       o_flag [4];

   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   int unsigned mb [4];
   int unsigned ml [4];
   bit          mf [4];
   int unsigned ob [4];
   bit          disc [4];
   logic [5:0]  pg [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : u
      localparam int unsigned AWG = (g < 2) ? 3 : 5;
      localparam bit          MDG = (g % 2) == 1;
      logic [AWG:0]   b, gy, lv;
      logic [AWG-1:0] ad;
      logic           fl;
      gray_fifo_ptr #(.ADDR_WIDTH(AWG), .MODE(MDG)) dut (
         .CLK(clk), .RST(rst), .inc(inc[g]), .clr(clr[g]),
         .sync_gray_ptr(sync[g][AWG:0]),
         .addr(ad), .bin_ptr(b), .gray_ptr(gy), .flag(fl), .level(lv)
      );
      assign o_bin[g]  = 6'(b);
      assign o_gray[g] = 6'(gy);
      assign o_lvl[g]  = 6'(lv);
      assign o_addr[g] = 5'(ad);
      assign o_flag[g] = fl;
   end

   function automatic int unsigned awof(input int i);
      return (i < 2) ? 3 : 5;
   endfunction

   function automatic bit mdof(input int i);
      return (i % 2) == 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic setob(input int i, input int unsigned v);
      ob[i]   = v;
      sync[i] = 6'(v ^ (v >> 1));
   endtask

   // Model: pointers as plain integers; occupancy is the modular distance,
   // full means a whole depth apart, empty means equal.
   always @(posedge clk or posedge rst) begin
      int unsigned n, m;
      for (int i = 0; i < 4; i++) begin
         n = 32'd1 << awof(i);
         m = 2 * n;
         if (rst || clr[i]) begin
            mb[i]   = 0;
            ml[i]   = 0;
            mf[i]   = mdof(i);
            disc[i] = 1'b1;
         end else begin
            if (inc[i] && !mf[i]) mb[i] = (mb[i] + 1) % m;
            ml[i] = mdof(i) ? (ob[i] + m - mb[i]) % m : (mb[i] + m - ob[i]) % m;
            mf[i] = mdof(i) ? (ml[i] == 0) : (ml[i] == n);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d.bin", i),   32'(o_bin[i]),  mb[i]);
            chk($sformatf("u%0d.gray", i),  32'(o_gray[i]), mb[i] ^ (mb[i] >> 1));
            chk($sformatf("u%0d.addr", i),  32'(o_addr[i]), mb[i] % (32'd1 << awof(i)));
            chk($sformatf("u%0d.flag", i),  32'(o_flag[i]), 32'(mf[i]));
            chk($sformatf("u%0d.level", i), 32'(o_lvl[i]),  ml[i]);
            if (!disc[i])
               chk($sformatf("u%0d.gray_step", i), 32'($countones(o_gray[i] ^ pg[i]) <= 1), 32'd1);
            pg[i]   = o_gray[i];
            disc[i] = 1'b0;
         end
      end
   end

   task automatic sweep(input int i);
      int unsigned m;
      m = 32'd2 << awof(i);
      for (int unsigned p = 0; p < m; p++) begin
         for (int unsigned s = 0; s < m; s++) begin
            setob(i, s);
            tick();
         end
         setob(i, mdof(i) ? (p + 2) % m : p);
         tick();
         inc[i] = 1'b1;
         tick();
         inc[i] = 1'b0;
      end
      chk($sformatf("u%0d.sweep_wrap", i), 32'(o_bin[i]), 32'd0);
   endtask

   initial begin
      int gseq [9];
      int unsigned p;
      gseq = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inc[i] = 1'b0;
         clr[i] = 1'b0;
         setob(i, 0);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      chk("rst.u0.flag", 32'(o_flag[0]), 32'd0);
      chk("rst.u1.flag", 32'(o_flag[1]), 32'd1);
      chk("rst.u2.bin", 32'(o_bin[2]), 32'd0);
      chk("rst.u3.level", 32'(o_lvl[3]), 32'd0);

      // write side fills to full, extra write dropped
      inc[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("fill.gray%0d", k), 32'(o_gray[0]), 32'(gseq[k]));
      end
      chk("fill.full", 32'(o_flag[0]), 32'd1);
      chk("fill.bin", 32'(o_bin[0]), 32'd8);
      chk("fill.level", 32'(o_lvl[0]), 32'd8);
      tick();
      inc[0] = 1'b0;
      chk("fill.drop", 32'(o_bin[0]), 32'd8);

      // reader moves to 1: full clears without any inc
      setob(0, 1);
      tick();
      chk("rd1.full", 32'(o_flag[0]), 32'd0);
      chk("rd1.level", 32'(o_lvl[0]), 32'd7);
      inc[0] = 1'b1;
      tick();
      inc[0] = 1'b0;
      chk("rd1.bin", 32'(o_bin[0]), 32'd9);
      chk("rd1.gray", 32'(o_gray[0]), 32'd13);
      chk("rd1.refull", 32'(o_flag[0]), 32'd1);

      // read side: empty blocks inc until the writer moves
      inc[1] = 1'b1;
      tick();
      chk("empty.drop", 32'(o_bin[1]), 32'd0);
      inc[1] = 1'b0;
      setob(1, 3);
      tick();
      chk("empty.clear", 32'(o_flag[1]), 32'd0);
      chk("empty.level", 32'(o_lvl[1]), 32'd3);
      inc[1] = 1'b1;
      repeat (3) tick();
      inc[1] = 1'b0;
      chk("drain.bin", 32'(o_bin[1]), 32'd3);
      chk("drain.level", 32'(o_lvl[1]), 32'd0);
      chk("drain.empty", 32'(o_flag[1]), 32'd1);

      // full lap on the read side with the writer kept ahead
      setob(1, 6);
      tick();
      p = 3;
      for (int k = 0; k < 16; k++) begin
         setob(1, (p + 4) % 16);
         inc[1] = 1'b1;
         tick();
         p = (p + 1) % 16;
         if (p == 0) chk("wrap.gray0", 32'(o_gray[1]), 32'd0);
      end
      chk("wrap.bin", 32'(o_bin[1]), 32'd3);

      // clr beats inc, then asynchronous reset mid-cycle
      repeat (2) tick();
      chk("clr.pre", 32'(o_bin[1]), 32'd5);
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      chk("clr.bin", 32'(o_bin[1]), 32'd0);
      chk("clr.gray", 32'(o_gray[1]), 32'd0);
      chk("clr.level", 32'(o_lvl[1]), 32'd0);
      chk("clr.empty", 32'(o_flag[1]), 32'd1);
      for (int k = 0; k < 20 && mb[1] != 6; k++) tick();
      inc[1] = 1'b0;
      chk("arst.pre", 32'(o_bin[1]), 32'd6);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("arst.u%0d.bin", i), 32'(o_bin[i]), 32'd0);
         chk($sformatf("arst.u%0d.gray", i), 32'(o_gray[i]), 32'd0);
         chk($sformatf("arst.u%0d.level", i), 32'(o_lvl[i]), 32'd0);
         chk($sformatf("arst.u%0d.flag", i), 32'(o_flag[i]), 32'(mdof(i)));
      end
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) setob(i, 0);
      tick();

      // every pointer value against every sync value
      fork
         sweep(0);
         sweep(1);
         sweep(2);
         sweep(3);
      join

      // randomized traffic with occasional clr and one async reset
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 4; i++) begin
            int unsigned n, m, r;
            n = 32'd1 << awof(i);
            m = 2 * n;
            inc[i] = 1'($urandom_range(0, 1));
            clr[i] = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
               r = $urandom_range(0, n);
               setob(i, mdof(i) ? (mb[i] + r) % m : (mb[i] + m - r) % m);
            end
         end
         if (c == 1000) begin
            rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         inc[i] = 1'b0;
         clr[i] = 1'b0;
      end
      repeat (2) tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gray_fifo_ptr.md
Name: gray_fifo_ptr

Overview:
- Parametrised Gray-coded FIFO pointer generator for the asynchronous FIFO between clock domains.
- Holds an (ADDR_WIDTH+1)-bit binary pointer and its registered Gray image for crossing to the other domain.
- Compares its next Gray value against the already-synchronised Gray pointer from the other domain to produce a registered full flag (write side) or empty flag (read side), plus a registered occupancy level.
- One instance per domain: MODE=0 on write side, MODE=1 on read side.

Parameters:
- ADDR_WIDTH, 3, FIFO address width; depth = 2**ADDR_WIDTH; legal range >= 2.
- MODE, 0, 0 = write side (flag is full), 1 = read side (flag is empty).

Ports:
- CLK  input  1  domain clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- inc  input  1  request to advance pointer by one (write or read strobe).
- clr  input  1  synchronous clear to reset state; priority over inc.
- sync_gray_ptr  input  ADDR_WIDTH+1  other domain's Gray pointer, already passed through the 2-flop synchroniser.
- addr  output  ADDR_WIDTH  memory address = bin_ptr[ADDR_WIDTH-1:0].
- bin_ptr  output  ADDR_WIDTH+1  registered binary pointer.
- gray_ptr  output  ADDR_WIDTH+1  registered Gray pointer, sent to synchroniser of other domain.
- flag  output  1  MODE=0: full; MODE=1: empty.
- level  output  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH.

Behaviour:
- Reset (RST=1, asynchronous, any time including mid-operation): bin_ptr=0, gray_ptr=0, level=0, flag=0 if MODE=0, flag=1 if MODE=1.
- clr=1 at a clock edge: same values as reset; inc is ignored that cycle.
- Effective advance: inc_eff = inc & ~flag. inc while full (write) or empty (read) is dropped with no pointer change.
- bin_next = bin_ptr + inc_eff, modulo 2**(ADDR_WIDTH+1), so it wraps from all-ones to 0.
- gray_next = bin_next ^ (bin_next >> 1).
- bin_ptr and gray_ptr are registered from bin_next and gray_next. gray_ptr must only ever change by one bit per cycle and must never be combinationally derived at the output.
- Flag, registered from next-state values, with one-cycle latency from inc:
  - MODE=0: full = (gray_next == {~sync[AW], ~sync[AW-1], sync[AW-2:0]}), where AW = ADDR_WIDTH.
  - MODE=1: empty = (gray_next == sync_gray_ptr).
- Sync conversion: sync_bin = Gray-to-binary of sync_gray_ptr, using the prefix-XOR from MSB: b[AW]=g[AW]; b[i]=b[i+1]^g[i].
- Level, registered, modulo 2**(ADDR_WIDTH+1):
  - MODE=0: level = bin_next - sync_bin.
  - MODE=1: level = sync_bin - bin_next.
- A change on sync_gray_ptr is reflected in flag and level at the next edge; no inc is needed.
- Simultaneous inc and sync change: both are applied in the same next-state computation.
- Flags are pessimistic by construction: full may stay set and empty may stay set for synchroniser latency. This is required behaviour.
- No combinational path from inc to flag or level.

Test Plan:
1. ADDR_WIDTH=3, MODE=0, sync=0; pulse inc 8 cycles -> gray_ptr steps 0000,0001,0011,0010,0110,0111,0101,0100,1100. After 8th edge: full=1, bin_ptr=8, level=8. 9th inc -> bin_ptr stays 8.
2. MODE=0 full state; set sync_gray_ptr=0001 (reader at 1) -> next edge full=0, level=7. One inc -> bin_ptr=9, gray=1101, full=1.
3. MODE=1, sync=0 -> empty=1 and inc ignored. Set sync=0010 (bin 3) -> next edge empty=0, level=3. Three incs -> bin_ptr=3, level=0, empty=1 after the third edge.
4. Wrap: MODE=1 with sync tracking ahead; 16 consumed increments -> bin_ptr 15->0, gray_ptr 1000->0000. Check every step changes exactly one gray bit.
5. clr=1 and inc=1 together at bin_ptr=5 -> bin_ptr=0, gray_ptr=0, level=0. Then assert RST asynchronously mid-cycle at bin_ptr=6 -> outputs zero (empty=1 if MODE=1) before the next edge.
6. Exhaustive: for ADDR_WIDTH=3 and 5, force every sync_gray_ptr value -> level matches the binary-decode reference model for all pointer pairs.
